display_string_streamer: RTL and testbench
==========================================

// Module: display_string_streamer
// PURPOSE
//  Reader end of the board_to_string interface: snapshots the 5000-bit ASCII
//  display_string when board_to_string raises done, then emits it one byte at a
//  time, MSB byte first, over a valid/ready byte stream to the UART transmitter.
//  NUL (8'h00) padding bytes are dropped, so left- or right-aligned strings both
//  render correctly. Sits between board_to_string and the UART TX.
// PARAMETERS
//  STR_BITS   5000  width of display_string; must be a multiple of CHAR_W
//  CHAR_W     8     bits per character
//  NUM_SLOTS  625   STR_BITS/CHAR_W byte slots scanned per frame (derived)
// PORTS
//  clk             in   1         system clock, rising edge
//  rst             in   1         asynchronous, active-high reset
//  display_string  in   STR_BITS  ASCII frame; first character in bits [STR_BITS-1 -: 8]
//  done            in   1         level from board_to_string; a rising edge starts a frame
//  tx_data         out  CHAR_W    character to transmit
//  tx_valid        out  1         tx_data is valid
//  tx_ready        in   1         UART TX accepts tx_data this cycle
//  busy            out  1         frame in progress
//  finished        out  1         one-cycle pulse: frame fully streamed
// BEHAVIOUR
//  - Reset (async): state=IDLE, shreg=0, slot_cnt=0, done_q=0; tx_valid=0,
//    tx_data=0, busy=0, finished=0. Takes effect mid-frame; no partial resume.
//  - start = done & ~done_q (done_q registered each cycle). Level-high done does
//    not retrigger; start while busy is ignored (frame not restarted or queued).
//  - States:
//    IDLE: on start -> shreg<=display_string, slot_cnt<=0, busy<=1, ->SCAN.
//    SCAN: examine top byte shreg[STR_BITS-1 -: 8]. If 8'h00: shift left 8,
//      slot_cnt+1, stay. If nonzero: ->SEND (no shift).
//    SEND: tx_valid=1, tx_data=top byte. On tx_valid&tx_ready: shift left 8,
//      slot_cnt+1, ->SCAN. Without ready: hold; tx_data stable, tx_valid never
//      drops until accepted.
//    Slot NUM_SLOTS-1 consumed (skipped in SCAN or accepted in SEND) -> FIN.
//    FIN: finished=1 for one cycle, busy<=0, ->IDLE.
//  - tx_valid and tx_data are registered outputs decoded from state/shreg;
//    tx_data=0 whenever tx_valid=0.
//  - Latency: start sampled at cycle 0 -> SCAN at cycle 1 -> first nonzero
//    byte at slot k gives tx_valid at cycle 2+k (zero-wait ready). Throughput
//    with ready held high: one character per 2 cycles (SCAN+SEND).
//  - slot_cnt is 10 bits; it never wraps (terminates at NUM_SLOTS-1).
//  - All-NUL string: no tx_valid; finished at cycle NUM_SLOTS+1 after start.
//  - display_string changes after start do not affect the frame (snapshot).
// STRUCTURE
//  - Shared package: CHAR_W, STR_BITS, NUM_SLOTS, ASCII_NUL, state encoding
//    localparams (IDLE/SCAN/SEND/FIN); also used by board_to_string.
//  - Shift register (left by CHAR_W) instead of a 625:1 byte mux.
//  - Single module; no sub-module (edge detect is inline).
// TESTING
//  - Board string (527 chars, 98 leading NUL slots), tx_ready=1 -> exactly 527
//    bytes, first 8'h2D ("-") at cycle 100, last 8'h0D, then one finished pulse.
//  - Same string, tx_ready toggled randomly -> byte sequence identical, tx_data
//    stable while tx_valid&~tx_ready, no drops or duplicates.
//  - display_string all zeros -> tx_valid never high, finished at cycle 626.
//  - done held high 3000 cycles, display_string changed mid-frame -> one frame
//    only, content of start-cycle snapshot.
//  - rst pulsed while in SEND at byte 200 -> tx_valid/busy low same cycle; next
//    done edge restarts from byte 0.
//  - Second done edge while busy -> ignored; exactly one finished pulse.

Source files
------------

// File: rtl/display_string_streamer_pkg.sv
// Shared constants and state encoding for the board_to_string / string streamer pair.
package display_string_streamer_pkg;

  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned STR_BITS  = 5000;
  localparam int unsigned NUM_SLOTS = STR_BITS / CHAR_W;
  localparam int unsigned SLOT_W    = 10;

  localparam logic [CHAR_W-1:0] ASCII_NUL = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } stream_state_e;

endpackage

// File: rtl/display_string_streamer.sv
// Snapshots display_string on a done rising edge and streams its non-NUL bytes,
// first character first, over a valid/ready byte interface.
module display_string_streamer
  import display_string_streamer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [STR_BITS-1:0] display_string,
  input  logic                done,
  output logic [CHAR_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                finished
);

  stream_state_e       state_q, state_d;
  logic [STR_BITS-1:0] shreg_q, shreg_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic                done_q, done_d;
  logic [CHAR_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;

  logic [CHAR_W-1:0]   top_byte;
  logic [STR_BITS-1:0] shreg_shifted;
  logic                last_slot;
  logic                start;

  assign top_byte      = shreg_q[STR_BITS-1 -: CHAR_W];
  assign shreg_shifted = {shreg_q[STR_BITS-CHAR_W-1:0], CHAR_W'(0)};
  assign last_slot     = (slot_cnt_q == SLOT_W'(NUM_SLOTS - 1));
  assign start         = done & ~done_q;

  // Next-state: the top byte of shreg is always the slot being examined.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    slot_cnt_d = slot_cnt_q;
    done_d     = done;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d    = display_string;
          slot_cnt_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (top_byte == ASCII_NUL) begin
          shreg_d = shreg_shifted;
          if (last_slot) state_d = ST_FIN;
          else           slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          shreg_d = shreg_shifted;
          if (last_slot) begin
            state_d = ST_FIN;
          end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            state_d    = ST_SCAN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    tx_valid_d = (state_d == ST_SEND);
    tx_data_d  = tx_valid_d ? shreg_d[STR_BITS-1 -: CHAR_W] : '0;
    busy_d     = (state_d != ST_IDLE);
    finished_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      slot_cnt_q <= '0;
      done_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      slot_cnt_q <= slot_cnt_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_display_string_streamer.sv
// Directed/randomised bench for display_string_streamer against a byte-queue reference model.
module tb_display_string_streamer;
  import display_string_streamer_pkg::*;

  logic                clk;
  logic                rst;
  logic [STR_BITS-1:0] display_string;
  logic                done;
  logic [CHAR_W-1:0]   tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                finished;

  display_string_streamer dut (
    .clk            (clk),
    .rst            (rst),
    .display_string (display_string),
    .done           (done),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .finished       (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int first_valid, fin_cyc, fin_cnt, proto_err, busy_c1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: the stream is simply every non-NUL character, first slot first.
  function automatic void model(input logic [STR_BITS-1:0] s);
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      b = s[STR_BITS-1-CHAR_W*i -: CHAR_W];
      if (b != 8'h00) exp_q.push_back(b);
    end
  endfunction

  function automatic int first_char_slot(input logic [STR_BITS-1:0] s);
    logic [7:0] b;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      b = s[STR_BITS-1-CHAR_W*i -: CHAR_W];
      if (b != 8'h00) return i;
    end
    return -1;
  endfunction

  function automatic int seq_diffs();
    int d;
    d = (got.size() > exp_q.size()) ? got.size() - exp_q.size() : exp_q.size() - got.size();
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic void put_byte(inout logic [STR_BITS-1:0] s, input int slot, input logic [7:0] b);
    s[STR_BITS-1-CHAR_W*slot -: CHAR_W] = b;
  endfunction

  // Runs one frame for ncyc cycles, counting cycles from the start-sampling edge.
  task automatic run_frame(input logic [STR_BITS-1:0] s, input logic [STR_BITS-1:0] s_alt,
                           input int ncyc, input bit rand_ready, input bit hold_done,
                           input int retrig_cyc);
    logic [7:0] last_data;
    bit pend;
    got.delete();
    first_valid = -1; fin_cyc = -1; fin_cnt = 0; proto_err = 0; busy_c1 = 0; pend = 0;
    last_data = 8'h00;
    @(negedge clk);
    display_string = s;
    done = 1'b1;
    tx_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (!hold_done && c == 1) done = 1'b0;
      if (retrig_cyc > 0 && c == retrig_cyc) done = 1'b1;
      if (retrig_cyc > 0 && c == retrig_cyc + 1) done = 1'b0;
      if (c == 5) display_string = s_alt;
      if (c == 1) busy_c1 = 32'(busy);
      if (pend && !(tx_valid && tx_data == last_data)) proto_err++;
      if (tx_valid && tx_data == 8'h00) proto_err++;
      if (!tx_valid && tx_data != 8'h00) proto_err++;
      if (tx_valid && first_valid < 0) first_valid = c;
      if (finished) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = c;
      end
      tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        pend = 0;
      end else if (tx_valid) begin
        pend = 1;
        last_data = tx_data;
      end else begin
        pend = 0;
      end
    end
    done = 1'b0;
    tx_ready = 1'b1;
  endtask

  logic [STR_BITS-1:0] board, other, lefty, zeros;
  int k;
  bit hit;

  initial begin
    rst = 1'b1;
    done = 1'b0;
    tx_ready = 1'b1;
    display_string = '0;
    zeros = '0;

    // Board: 98 leading NULs, '-' first, CR last, 527 characters in total.
    board = '0;
    put_byte(board, 98, 8'h2D);
    for (int i = 99; i < 624; i++) put_byte(board, i, 8'($urandom_range(32, 126)));
    put_byte(board, 624, 8'h0D);

    // Left-aligned string with scattered NULs and trailing padding.
    lefty = '0;
    for (int i = 0; i < 400; i++)
      put_byte(lefty, i, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(33, 126)));
    put_byte(lefty, 0, 8'h41);

    other = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) put_byte(other, i, 8'($urandom_range(33, 126)));

    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finished", 32'(finished), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Board string, ready always high.
    model(board);
    chk("board_len_model", exp_q.size(), 527);
    run_frame(board, board, 1300, 0, 0, 0);
    chk("board_busy_c1", busy_c1, 1);
    chk("board_first_cyc", first_valid, 2 + first_char_slot(board));
    chk("board_first_cyc_abs", first_valid, 100);
    chk("board_count", got.size(), 527);
    chk("board_seq", seq_diffs(), 0);
    chk("board_first_byte", (got.size() > 0) ? 32'(got[0]) : -1, 32'h2D);
    chk("board_last_byte", (got.size() > 0) ? 32'(got[got.size()-1]) : -1, 32'h0D);
    chk("board_fin_cyc", fin_cyc, 1 + int'(NUM_SLOTS) + exp_q.size());
    chk("board_fin_cnt", fin_cnt, 1);
    chk("board_proto", proto_err, 0);
    chk("board_busy_end", 32'(busy), 0);

    // Same string, random backpressure.
    run_frame(board, board, 3000, 1, 0, 0);
    chk("bp_first_cyc", first_valid, 100);
    chk("bp_seq", seq_diffs(), 0);
    chk("bp_proto", proto_err, 0);
    chk("bp_fin_cnt", fin_cnt, 1);

    // Left-aligned string with interior NULs, random backpressure.
    model(lefty);
    run_frame(lefty, lefty, 3000, 1, 0, 0);
    chk("left_first_cyc", first_valid, 2);
    chk("left_seq", seq_diffs(), 0);
    chk("left_proto", proto_err, 0);
    chk("left_fin_cnt", fin_cnt, 1);

    // All-NUL frame.
    model(zeros);
    run_frame(zeros, zeros, 700, 0, 0, 0);
    chk("nul_no_valid", first_valid, -1);
    chk("nul_count", got.size(), 0);
    chk("nul_fin_cyc", fin_cyc, int'(NUM_SLOTS) + 1);
    chk("nul_fin_cnt", fin_cnt, 1);

    // done held high, string changed mid-frame: one frame of the snapshot.
    model(board);
    run_frame(board, other, 3000, 0, 1, 0);
    chk("hold_seq", seq_diffs(), 0);
    chk("hold_fin_cnt", fin_cnt, 1);
    chk("hold_proto", proto_err, 0);

    // Second done edge while busy is ignored.
    model(lefty);
    run_frame(lefty, lefty, 1300, 0, 0, 50);
    chk("retrig_seq", seq_diffs(), 0);
    chk("retrig_fin_cnt", fin_cnt, 1);

    // Reset while presenting byte 200, then restart from byte 0.
    model(board);
    got.delete();
    @(negedge clk);
    display_string = board;
    done = 1'b1;
    tx_ready = 1'b1;
    hit = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) done = 1'b0;
      if (tx_valid && got.size() == 200) begin
        hit = 1;
        break;
      end
      if (tx_valid) got.push_back(tx_data);
    end
    chk("rst_reach_200", 32'(hit), 1);
    chk("rst_byte200", 32'(tx_data), 32'(exp_q[200]));
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid || busy) k++;
    end
    chk("midrst_stays_idle", k, 0);
    run_frame(board, board, 1300, 0, 0, 0);
    chk("restart_first_cyc", first_valid, 100);
    chk("restart_seq", seq_diffs(), 0);
    chk("restart_fin_cnt", fin_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
